// File: rtl/seg6_decode_if.sv
// rtl/seg6_decode_if.sv - segment capture bus: multiplexed segment/digit-select in, decoded frame out
interface seg6_decode_if;
    logic [6:0]  iSEG;
    logic [5:0]  iDIG_EN;
    logic [23:0] oDIG;
    logic        oVALID;
    logic        oERR;
    logic [5:0]  oERR_MASK;
    logic        oTIMEOUT;

    modport master (
        output iSEG, iDIG_EN,
        input  oDIG, oVALID, oERR, oERR_MASK, oTIMEOUT
    );

    modport slave (
        input  iSEG, iDIG_EN,
        output oDIG, oVALID, oERR, oERR_MASK, oTIMEOUT
    );
endinterface

// File: rtl/seg6_decode.sv
// rtl/seg6_decode.sv - recovers a 24-bit hex value from a six-digit multiplexed active-low segment bus
module seg6_decode #(
    parameter int STABLE  = 4,
    parameter int TIMEOUT = 65536
) (
    input  logic         iCLK,
    input  logic         iRST,
    seg6_decode_if.slave bus
);
    localparam int             IW  = $clog2(TIMEOUT + 1);
    localparam logic [7:0]     STB = 8'(STABLE);
    localparam logic [IW-1:0]  TMO = IW'(TIMEOUT);

    logic [6:0]    seg_q, prev_seg_q;
    logic [5:0]    en_q, prev_en_q;
    logic [7:0]    cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [23:0]   slot_q, slot_d;
    logic [5:0]    slot_err_q, slot_err_d;
    logic [5:0]    seen_q, seen_d;
    logic          done_q, done_d;
    logic [23:0]   dig_q, dig_d;
    logic [5:0]    mask_q, mask_d;
    logic          err_q, err_d;
    logic          valid_q, valid_d;
    logic          tmo_q, tmo_d;

    logic          one_hot, same, accept;
    logic [2:0]    idx;
    logic [3:0]    dec_nib;
    logic          dec_err;

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0010000: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b0000011: r = 5'h0B;
            7'b1000110: r = 5'h0C;
            7'b0100001: r = 5'h0D;
            7'b0000110: r = 5'h0E;
            7'b0001110: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    assign one_hot = (en_q != 6'd0) && ((en_q & (en_q - 6'd1)) == 6'd0);
    assign same    = (seg_q == prev_seg_q) && (en_q == prev_en_q);
    assign {dec_err, dec_nib} = decode(seg_q);

    always_comb begin
        idx = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (en_q[k]) idx = 3'(k);
        end
    end

    always_comb begin
        cnt_d = 8'd0;
        if (one_hot && same) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        else if (one_hot)    cnt_d = 8'd1;
    end

    // Only the edge on which the count first arrives at STABLE accepts, so a held pattern counts once
    assign accept = one_hot && (cnt_d == STB) && (cnt_q != STB);

    always_comb begin
        slot_d     = slot_q;
        slot_err_d = slot_err_q;
        seen_d     = seen_q;
        done_d     = 1'b0;
        idle_d     = idle_q;
        dig_d      = dig_q;
        mask_d     = mask_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        tmo_d      = 1'b0;

        if (done_q) begin
            dig_d   = slot_q;
            mask_d  = slot_err_q;
            err_d   = |slot_err_q;
            valid_d = 1'b1;
            seen_d  = 6'd0;
        end

        if (accept) begin
            slot_d[{idx, 2'b00} +: 4] = dec_nib;
            slot_err_d[idx]           = dec_err;
            seen_d                    = seen_d | en_q;
            done_d                    = (seen_d == 6'h3F);
            idle_d                    = '0;
        end else if (idle_q == TMO) begin
            if (seen_q != 6'd0) begin
                seen_d = 6'd0;
                tmo_d  = 1'b1;
                idle_d = '0;
            end
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Cleared sample registers hold a zero digit select, which never matches a one-hot sample
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            seg_q      <= 7'd0;
            en_q       <= 6'd0;
            prev_seg_q <= 7'd0;
            prev_en_q  <= 6'd0;
            cnt_q      <= 8'd0;
            idle_q     <= '0;
            slot_q     <= 24'd0;
            slot_err_q <= 6'd0;
            seen_q     <= 6'd0;
            done_q     <= 1'b0;
            dig_q      <= 24'd0;
            mask_q     <= 6'd0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            seg_q      <= bus.iSEG;
            en_q       <= bus.iDIG_EN;
            prev_seg_q <= seg_q;
            prev_en_q  <= en_q;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            slot_q     <= slot_d;
            slot_err_q <= slot_err_d;
            seen_q     <= seen_d;
            done_q     <= done_d;
            dig_q      <= dig_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.oDIG      = dig_q;
    assign bus.oERR_MASK = mask_q;
    assign bus.oERR      = err_q;
    assign bus.oVALID    = valid_q;
    assign bus.oTIMEOUT  = tmo_q;
endmodule

// File: tb/tb_seg6_decode.sv
// tb/tb_seg6_decode.sv - directed scans against a frame scoreboard for seg6_decode
module tb_seg6_decode;
    localparam int STB = 4;
    localparam int TMO = 64;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    seg6_decode_if bus ();

    seg6_decode #(.STABLE(STB), .TIMEOUT(TMO)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    typedef struct packed {
        logic [23:0] dig;
        logic [5:0]  mask;
    } frame_t;

    frame_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_tmo   = 0;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (bus.oTIMEOUT === 1'b1) n_tmo++;
        if (bus.oVALID === 1'b1) begin
            frame_t f;
            n_valid++;
            check("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                f = sb.pop_front();
                check("oDIG", 32'(bus.oDIG), 32'(f.dig));
                check("oERR_MASK", 32'(bus.oERR_MASK), 32'(f.mask));
                check("oERR", 32'(bus.oERR), 32'(|f.mask));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic put(input int k, input logic [6:0] p, input int n);
        bus.iDIG_EN = 6'(1 << k);
        bus.iSEG    = p;
        cyc(n);
    endtask

    task automatic scan(input logic [23:0] v, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) put(k, enc(v[k*4 +: 4]), STB);
    endtask

    task automatic idle(input int n);
        bus.iDIG_EN = 6'd0;
        bus.iSEG    = 7'h7F;
        cyc(n);
    endtask

    task automatic expect_frame(input logic [23:0] d, input logic [5:0] m);
        frame_t f;
        f.dig  = d;
        f.mask = m;
        sb.push_back(f);
    endtask

    task automatic drain(input string tag);
        idle(12);
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_oDIG"}, 32'(bus.oDIG), 32'd0);
        check({tag, "_oVALID"}, 32'(bus.oVALID), 32'd0);
        check({tag, "_oERR"}, 32'(bus.oERR), 32'd0);
        check({tag, "_oERR_MASK"}, 32'(bus.oERR_MASK), 32'd0);
        check({tag, "_oTIMEOUT"}, 32'(bus.oTIMEOUT), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.iDIG_EN = 6'd0;
        bus.iSEG    = 7'h7F;
        iRST        = 1'b1;
        cyc(3);
        check_zero_outputs("reset");
        iRST = 1'b0;
        idle(2);

        // plain scan
        expect_frame(24'h012345, 6'd0);
        scan(24'h012345, 0, 5);
        drain("scan");
        check("scan_valid_count", 32'(n_valid), 32'd1);

        // digit 2 held one cycle short; frame completes partway into the repeat scan
        scan(24'h012345, 0, 1);
        put(2, enc(4'h3), STB - 1);
        scan(24'h012345, 3, 5);
        expect_frame(24'h012345, 6'd0);
        scan(24'h012345, 0, 5);
        drain("short");
        check("short_valid_count", 32'(n_valid), 32'd2);
        idle(TMO + 20);
        check("short_leftover_tmo", 32'(n_tmo), 32'd1);

        // undecodable digit 4
        scan(24'h012345, 0, 3);
        expect_frame(24'h002345, 6'b010000);
        put(4, 7'h7F, STB);
        scan(24'h012345, 5, 5);
        drain("bad");
        check("bad_valid_count", 32'(n_valid), 32'd3);

        // partial frame discarded on timeout, then a fresh frame
        scan(24'hABCDEF, 0, 2);
        idle(TMO + 20);
        check("tmo_pulse", 32'(n_tmo), 32'd2);
        check("tmo_no_valid", 32'(n_valid), 32'd3);
        expect_frame(24'hABCDEF, 6'd0);
        scan(24'hABCDEF, 0, 5);
        drain("after_tmo");
        check("after_tmo_valid_count", 32'(n_valid), 32'd4);

        // multi-bit digit select mid-scan is ignored
        scan(24'h5A3C71, 0, 2);
        bus.iDIG_EN = 6'b000011;
        bus.iSEG    = enc(4'h9);
        cyc(20);
        expect_frame(24'h5A3C71, 6'd0);
        scan(24'h5A3C71, 3, 5);
        drain("multi");
        check("multi_valid_count", 32'(n_valid), 32'd5);
        check("multi_tmo_count", 32'(n_tmo), 32'd2);

        // reset mid-frame
        scan(24'h13579B, 0, 2);
        iRST = 1'b1;
        cyc(2);
        check_zero_outputs("midrst");
        iRST = 1'b0;
        expect_frame(24'hFEDCBA, 6'd0);
        scan(24'hFEDCBA, 0, 5);
        drain("post_rst");
        check("post_rst_valid_count", 32'(n_valid), 32'd6);
        idle(TMO + 20);
        check("empty_no_tmo", 32'(n_tmo), 32'd2);
        check("hold_oDIG", 32'(bus.oDIG), 32'h00FEDCBA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
